// File: rtl/udp_tx_scheduler_if.sv
// Requester and MAC-FIFO signal bundle for udp_tx_scheduler.
// master: the scheduler's view; slave: the requesters/FIFO/MAC view.
interface udp_tx_scheduler_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   src_valid;
    logic [4*NUM_REQ-1:0] src_data;
    logic [NUM_REQ-1:0]   src_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 wr_en;
    logic [3:0]           wr_data;
    logic                 wr_full;
    logic                 wr_rst_busy;
    logic                 mac_busy;

    modport master (
        input  req, src_valid, src_data, wr_full, wr_rst_busy, mac_busy,
        output src_ready, grant, wr_en, wr_data
    );

    modport slave (
        output req, src_valid, src_data, wr_full, wr_rst_busy, mac_busy,
        input  src_ready, grant, wr_en, wr_data
    );
endinterface

// File: rtl/udp_tx_scheduler.sv
// udp_tx_scheduler: round-robin arbiter that streams one fixed-size UDP
// payload (PACKET_NIBBLES nibbles) from the granted requester into the MAC
// FIFO, zero-pads short packets, then waits for the MAC to send the frame.
// Optional WAIT_MAC watchdog: define UDP_TX_SCHEDULER_TIMEOUT_EN.
module udp_tx_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int PACKET_NIBBLES = 512,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic               clk,
    input  logic               reset,
    udp_tx_scheduler_if.master bus,
    output logic               busy,
    output logic [15:0]        pkt_count,
    output logic               timeout
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(PACKET_NIBBLES + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(PACKET_NIBBLES - 1);
    localparam logic [IW-1:0] IDX_RESET = IW'(NUM_REQ - 1);

    // Elaboration-time guard on the supported parameter ranges.
    if (NUM_REQ < 2 || NUM_REQ > 8 || PACKET_NIBBLES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("udp_tx_scheduler: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        PAD,
        WAIT_MAC
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      last_grant_q, last_grant_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               wr_en_q, wr_en_d;
    logic [3:0]         wr_data_q, wr_data_d;
    logic [15:0]        pkt_count_q, pkt_count_d;
    logic               mac_seen_q, mac_seen_d;

    logic               req_g;
    logic               valid_g;
    logic [3:0]         nibble_g;
    logic               rr_found;
    logic [IW-1:0]      rr_idx;
    logic               xfer;
    logic               pad_wr;

`ifdef UDP_TX_SCHEDULER_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] wd_q, wd_d;
    logic          timeout_q, timeout_d;
`endif

    // Select the granted requester's req/valid/nibble.
    always_comb begin
        req_g    = 1'b0;
        valid_g  = 1'b0;
        nibble_g = 4'h0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gidx_q == IW'(i)) begin
                req_g    = bus.req[i];
                valid_g  = bus.src_valid[i];
                nibble_g = bus.src_data[4*i +: 4];
            end
        end
    end

    // Round-robin pick: lowest active index above last_grant, else wrap to the lowest at or below it.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!rr_found && bus.req[i] && (IW'(i) > last_grant_q)) begin
                rr_found = 1'b1;
                rr_idx   = IW'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!rr_found && bus.req[i] && (IW'(i) <= last_grant_q)) begin
                rr_found = 1'b1;
                rr_idx   = IW'(i);
            end
        end
    end

    // Next-state, nibble counter, FIFO write and packet bookkeeping.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        gidx_d       = gidx_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        pkt_count_d  = pkt_count_q;
        mac_seen_d   = mac_seen_q;
        xfer         = 1'b0;
        pad_wr       = 1'b0;
`ifdef UDP_TX_SCHEDULER_TIMEOUT_EN
        wd_d         = '0;
        timeout_d    = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (rr_found && !bus.wr_rst_busy && !bus.mac_busy) begin
                    state_d      = STREAM;
                    gidx_d       = rr_idx;
                    last_grant_d = rr_idx;
                    grant_d      = NUM_REQ'(1) << rr_idx;
                end
            end
            STREAM: begin
                xfer = valid_g && !bus.wr_full;
                if (!req_g) begin
                    state_d = PAD;
                end
            end
            PAD: begin
                pad_wr = !bus.wr_full;
            end
            WAIT_MAC: begin
                if (bus.mac_busy) begin
                    mac_seen_d = 1'b1;
                end else if (mac_seen_q) begin
                    mac_seen_d  = 1'b0;
                    pkt_count_d = pkt_count_q + 16'd1;
                    state_d     = IDLE;
                end
`ifdef UDP_TX_SCHEDULER_TIMEOUT_EN
                wd_d = wd_q + WW'(1);
                // A completed handshake in the same cycle takes precedence over expiry.
                if (state_d == WAIT_MAC && wd_q == WD_LAST) begin
                    timeout_d  = 1'b1;
                    mac_seen_d = 1'b0;
                    state_d    = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // The final write overrides a PAD decision taken in the same cycle.
        if (xfer || pad_wr) begin
            wr_en_d   = 1'b1;
            wr_data_d = xfer ? nibble_g : 4'h0;
            if (cnt_q == CNT_LAST) begin
                cnt_d      = '0;
                grant_d    = '0;
                mac_seen_d = 1'b0;
                state_d    = WAIT_MAC;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            gidx_q       <= '0;
            last_grant_q <= IDX_RESET;
            cnt_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= 4'h0;
            pkt_count_q  <= 16'h0000;
            mac_seen_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            gidx_q       <= gidx_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            pkt_count_q  <= pkt_count_d;
            mac_seen_q   <= mac_seen_d;
        end
    end

`ifdef UDP_TX_SCHEDULER_TIMEOUT_EN
    // Watchdog counter and timeout pulse register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign bus.src_ready = (state_q == STREAM && !bus.wr_full) ? grant_q : '0;
    assign bus.grant     = grant_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_data   = wr_data_q;
    assign busy          = (state_q != IDLE);
    assign pkt_count     = pkt_count_q;
endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Directed bench for udp_tx_scheduler: NUM_REQ=2, PACKET_NIBBLES=8, TIMEOUT_CYCLES=100.
module tb_udp_tx_scheduler;
    logic        clk;
    logic        reset;
    logic        busy;
    logic [15:0] pkt_count;
    logic        timeout;
    int          total;
    int          bad;
    logic [15:0] exp_pkt;

    udp_tx_scheduler_if #(.NUM_REQ(2)) bus ();

    udp_tx_scheduler #(
        .NUM_REQ(2),
        .PACKET_NIBBLES(8),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .busy(busy),
        .pkt_count(pkt_count),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a grant, then compare it.
    task automatic wait_grant(input string tag, input logic [1:0] exp);
        int n;
        n = 0;
        while (bus.grant == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.grant), 32'(exp));
    endtask

    // Stream one packet from requester g; req[g] is dropped after 'drop' transfers,
    // wr_full is held for fl cycles starting at loop cycle fs.
    task automatic run_pkt(input int g, input int drop, input int fs, input int fl);
        int   sent;
        int   writes;
        logic xfer;
        logic [1:0] g_exp;
        g_exp = 2'(1 << g);
        wait_grant("grant", g_exp);
        sent   = 0;
        writes = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            bus.wr_full = (cyc >= fs && cyc < fs + fl);
            if (sent >= drop) begin
                bus.req[g]       = 1'b0;
                bus.src_valid[g] = 1'b0;
            end else begin
                bus.src_valid[g]       = 1'b1;
                bus.src_data[4*g +: 4] = 4'(sent + 1);
            end
            #1;
            if (bus.wr_full) chk("ready_low_when_full", 32'(bus.src_ready), 32'd0);
            xfer = bus.src_valid[g] && bus.src_ready[g];
            @(negedge clk);
            if (xfer) sent++;
            if (bus.wr_en) begin
                chk("wr_data", 32'(bus.wr_data), (writes < drop) ? 32'(writes + 1) : 32'd0);
                writes++;
            end
            if (bus.grant == 2'b00) break;
        end
        chk("write_count", 32'(writes), 32'd8);
        chk("busy_in_wait_mac", 32'(busy), 32'd1);
        bus.wr_full      = 1'b0;
        bus.src_valid[g] = 1'b0;
    endtask

    // mac_busy high for 3 cycles then low; pkt_count bumps and busy drops on the next cycle.
    task automatic mac_done(input logic [15:0] exp_cnt);
        bus.mac_busy = 1'b1;
        repeat (3) @(negedge clk);
        chk("wait_mac_wr_en", 32'(bus.wr_en), 32'd0);
        chk("pkt_hold", 32'(pkt_count), 32'(exp_cnt - 16'd1));
        chk("busy_hold", 32'(busy), 32'd1);
        bus.mac_busy = 1'b0;
        @(negedge clk);
        chk("busy_fall", 32'(busy), 32'd0);
        chk("pkt_count", 32'(pkt_count), 32'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int  k;
        logic saw;
        total = 0;
        bad   = 0;
        exp_pkt = 16'd0;
        reset = 1'b1;
        bus.req = 2'b00;
        bus.src_valid = 2'b00;
        bus.src_data = 8'h00;
        bus.wr_full = 1'b0;
        bus.wr_rst_busy = 1'b0;
        bus.mac_busy = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_src_ready", 32'(bus.src_ready), 32'd0);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;

        // Both requesters held: grants alternate 0,1,0,1.
        bus.req = 2'b11;
        run_pkt(0, 8, 99, 0); exp_pkt = 16'd1; mac_done(exp_pkt);
        run_pkt(1, 8, 99, 0); exp_pkt = 16'd2; mac_done(exp_pkt);
        run_pkt(0, 8, 99, 0); exp_pkt = 16'd3; mac_done(exp_pkt);
        run_pkt(1, 8, 99, 0);
        bus.req = 2'b01;
        exp_pkt = 16'd4; mac_done(exp_pkt);

        // wr_full high for 3 cycles mid-packet: data 1..8 without loss or repeat.
        run_pkt(0, 8, 3, 3);
        exp_pkt = 16'd5; mac_done(exp_pkt);

        // req[0] dropped after 3 nibbles: 3 data writes then 5 pad zeros.
        run_pkt(0, 3, 99, 0);
        chk("req_dropped", 32'(bus.req), 32'd0);
        exp_pkt = 16'd6; mac_done(exp_pkt);
        repeat (2) @(negedge clk);
        chk("idle_no_req", 32'(busy), 32'd0);

        // IDLE holds off while the FIFO is in reset or the MAC is busy.
        bus.req = 2'b10;
        bus.wr_rst_busy = 1'b1;
        repeat (3) @(negedge clk);
        chk("gate_rst_busy_grant", 32'(bus.grant), 32'd0);
        chk("gate_rst_busy_busy", 32'(busy), 32'd0);
        bus.wr_rst_busy = 1'b0;
        bus.mac_busy = 1'b1;
        repeat (3) @(negedge clk);
        chk("gate_mac_busy_grant", 32'(bus.grant), 32'd0);
        bus.mac_busy = 1'b0;
        run_pkt(1, 8, 99, 0);
        bus.req = 2'b00;

`ifdef UDP_TX_SCHEDULER_TIMEOUT_EN
        // mac_busy never rises: timeout pulse 100 cycles after entering WAIT_MAC.
        k = 0;
        while (!timeout && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("to_cycles", 32'(k), 32'd100);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_pkt_count", 32'(pkt_count), 32'(exp_pkt));
        @(negedge clk);
        chk("to_pulse_width", 32'(timeout), 32'd0);
`else
        // Without the watchdog WAIT_MAC waits indefinitely.
        saw = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (timeout) saw = 1'b1;
        end
        chk("no_timeout", 32'(saw), 32'd0);
        chk("still_waiting", 32'(busy), 32'd1);
        exp_pkt = 16'd7; mac_done(exp_pkt);
`endif

        // Reset at nibble 4 abandons the packet and restores round-robin order.
        bus.req = 2'b01;
        wait_grant("pre_rst_grant", 2'b01);
        bus.src_valid[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.src_data[3:0] = 4'(i + 1);
            @(negedge clk);
        end
        chk("pre_rst_wr_en", 32'(bus.wr_en), 32'd1);
        chk("pre_rst_wr_data", 32'(bus.wr_data), 32'd4);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("mid_rst_grant", 32'(bus.grant), 32'd0);
        chk("mid_rst_pkt_count", 32'(pkt_count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        bus.src_valid = 2'b00;
        bus.req = 2'b11;
        @(negedge clk);
        wait_grant("post_rst_grant", 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/udp_tx_scheduler.md
UDP_TX_SCHEDULER -- requirements
Module: udp_tx_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2: number of packet requesters, range 2..8.
REQ-002 The block SHALL have parameter PACKET_NIBBLES, default 512: nibbles per UDP payload, equal to 2*MIN_DATA_BYTES of the UDP transmitter.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 10_000_000: the WAIT_MAC watchdog limit in clk cycles.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock, 100 MHz; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req, input, NUM_REQ bits: per-requester packet request, held high until the packet is complete.
REQ-007 The block SHALL have port src_valid, input, NUM_REQ bits: per-requester nibble valid.
REQ-008 The block SHALL have port src_data, input, 4*NUM_REQ bits: requester i drives bits [4i+3:4i].
REQ-009 The block SHALL have port src_ready, output, NUM_REQ bits: per-requester nibble accept.
REQ-010 The block SHALL have port grant, output, NUM_REQ bits: one-hot registered owner, zero when no owner.
REQ-011 The block SHALL have port wr_en, output, 1 bit: MAC FIFO write strobe.
REQ-012 The block SHALL have port wr_data, output, 4 bits: MAC FIFO write nibble.
REQ-013 The block SHALL have port wr_full, input, 1 bit: MAC FIFO full.
REQ-014 The block SHALL have port wr_rst_busy, input, 1 bit: MAC FIFO in reset.
REQ-015 The block SHALL have port mac_busy, input, 1 bit: the MAC is transmitting a frame.
REQ-016 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-017 The block SHALL have port pkt_count, output, 16 bits: number of completed packets.
REQ-018 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when the watchdog expires.

Function
REQ-019 The block SHALL implement the states IDLE, STREAM, PAD and WAIT_MAC.
REQ-020 In IDLE, the block SHALL move to STREAM when req is nonzero, wr_rst_busy=0 and mac_busy=0, registering grant to the winner.
REQ-021 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ, and last_grant updates on each grant.
REQ-022 src_ready[i] SHALL be high only in STREAM for the granted requester, and only while wr_full=0; all other src_ready bits SHALL be 0.
REQ-023 A transfer SHALL occur when src_valid[g] and src_ready[g] are both high; one cycle later wr_en=1 and wr_data equals that nibble.
REQ-024 wr_en SHALL be 0 in every cycle without a transfer or pad write.
REQ-025 Each transfer or pad write SHALL increment the nibble counter; on the write that makes it PACKET_NIBBLES, the block SHALL go to WAIT_MAC, clear grant and reset the counter.
REQ-026 If req[g]=0 is sampled in STREAM before the count completes, the block SHALL enter PAD the next cycle; a transfer in that same sampled cycle still counts.
REQ-027 In PAD, the block SHALL write nibble 0x0 on each cycle with wr_full=0 until the count completes, then go to WAIT_MAC.
REQ-028 In WAIT_MAC, the block SHALL wait for mac_busy to be seen high and then low; at that point it SHALL increment pkt_count (wrapping 0xFFFF to 0x0000) and return to IDLE.
REQ-029 When wr_full and src_valid are high in the same cycle, the block SHALL make no transfer and SHALL drop no data.
REQ-030 Changes on req from non-granted requesters during STREAM, PAD or WAIT_MAC SHALL be ignored until IDLE.

Reset
REQ-031 With reset high, the block SHALL go to IDLE with grant=0, src_ready=0, wr_en=0, wr_data=0, busy=0, pkt_count=0, timeout=0, counter=0 and last_grant=NUM_REQ-1.
REQ-032 A reset mid-packet SHALL abandon the packet, and wr_en SHALL be 0 from the first cycle after reset is sampled.

Configuration
REQ-033 With macro UDP_TX_SCHEDULER_TIMEOUT_EN defined, the block SHALL count cycles in WAIT_MAC; on reaching TIMEOUT_CYCLES it SHALL pulse timeout, return to IDLE and leave pkt_count unchanged.
REQ-034 Without UDP_TX_SCHEDULER_TIMEOUT_EN, WAIT_MAC SHALL wait indefinitely, timeout SHALL be tied to 0 and no watchdog counter SHALL exist.

Verification
REQ-035 The bench SHALL cover: NUM_REQ=2, PACKET_NIBBLES=8, req=2'b11 held -> grants in order 0,1,0,1, each with exactly 8 wr_en pulses.
REQ-036 The bench SHALL cover: requester 0 streams 1..8 with wr_full high for 3 cycles mid-packet -> wr_data sequence 1..8, no gaps in data, no duplicates.
REQ-037 The bench SHALL cover: req[0] dropped after 3 nibbles -> 3 data writes then 5 writes of 0x0, then WAIT_MAC.
REQ-038 The bench SHALL cover: mac_busy pulse high then low in WAIT_MAC -> pkt_count increments by 1 and busy falls the next cycle.
REQ-039 The bench SHALL cover: UDP_TX_SCHEDULER_TIMEOUT_EN with TIMEOUT_CYCLES=100 and mac_busy held 0 -> timeout pulse at cycle 100, IDLE, pkt_count unchanged.
REQ-040 The bench SHALL cover: reset asserted at nibble 4 -> wr_en=0, grant=0, pkt_count=0, and the next grant goes to requester 0.
